// File: rtl/int_rx_alu_loader_pkg.sv
// Shared constants for the UART calculator RX/TX ALU interfaces: ASCII codes,
// ALU opcodes and the RX parser state encoding.
package int_rx_alu_loader_pkg;

  localparam logic [7:0] ASCII_0    = 8'd48;
  localparam logic [7:0] ASCII_9    = 8'd57;
  localparam logic [7:0] ASCII_COMA = 8'h2C;
  localparam logic [7:0] ASCII_CR   = 8'h0D;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_SRL = 6'b000011;
  localparam logic [5:0] OP_SLL = 6'b000010;

  typedef enum logic [2:0] {
    CAMPO_A  = 3'd0,
    CAMPO_B  = 3'd1,
    CAMPO_OP = 3'd2,
    FIN      = 3'd3,
    LISTO    = 3'd4,
    DESCARTE = 3'd5
  } state_t;

endpackage

// File: rtl/int_rx_alu_loader_ascii_op_decode.sv
// Combinational ASCII operator character to ALU opcode lookup.
module ascii_op_decode
  import int_rx_alu_loader_pkg::*;
(
  input  logic [7:0] i_char,
  output logic       o_valid,
  output logic [5:0] o_opcode
);

  always_comb begin
    o_valid  = 1'b1;
    o_opcode = '0;
    case (i_char)
      8'h2B:   o_opcode = OP_ADD;  // '+'
      8'h2D:   o_opcode = OP_SUB;  // '-'
      8'h26:   o_opcode = OP_AND;  // '&'
      8'h7C:   o_opcode = OP_OR;   // '|'
      8'h5E:   o_opcode = OP_XOR;  // '^'
      8'h7E:   o_opcode = OP_NOR;  // '~'
      8'h72:   o_opcode = OP_SRL;  // 'r'
      8'h6C:   o_opcode = OP_SLL;  // 'l'
      default: o_valid  = 1'b0;
    endcase
  end

endmodule

// File: rtl/int_rx_alu_loader.sv
// Parses "<A>,<B>,<op>CR" frames popped from the RX FIFO and loads the ALU operands.
// Build option INT_RX_SAT_EN: saturate operand fields above 255 instead of wrapping.
module int_rx_alu_loader
  import int_rx_alu_loader_pkg::*;
#(
  parameter int MAX_DIGITS = 3
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       fifo_empty,
  input  logic [7:0] rd_data,
  output logic       RD_FIFO,
  output logic [7:0] DATO_A,
  output logic [7:0] DATO_B,
  output logic [5:0] OPCODE,
  output logic       ejecutar,
  output logic       error,
  output logic [2:0] o_dbg_state
);

  // FIFO handshake: a byte is consumed on the rising edge of any cycle where
  // RD_FIFO is high; rd_data is only looked at while fifo_empty is low.
  localparam logic [1:0] MAX_CNT = 2'(MAX_DIGITS);

  state_t     r_state, w_next;
  logic [9:0] r_acc;
  logic [1:0] r_cnt;
  logic [7:0] r_sh_a, r_sh_b, r_dato_a, r_dato_b;
  logic [5:0] r_sh_op, r_opcode;
  logic       r_error;

  logic       w_avail, w_pop, w_is_digit, w_op_valid;
  logic       w_acc_add, w_acc_clr, w_load_a, w_load_b, w_load_op, w_err, w_commit;
  logic [5:0] w_op_code;
  logic [9:0] w_acc_next;
  logic [7:0] w_field;

  ascii_op_decode u_op_decode (
    .i_char   (rd_data),
    .o_valid  (w_op_valid),
    .o_opcode (w_op_code)
  );

  assign w_avail    = !fifo_empty && !RESET;
  assign w_is_digit = (rd_data >= ASCII_0) && (rd_data <= ASCII_9);
  // Low nibble of '0'..'9' is the digit value.
  assign w_acc_next = r_acc * 10'd10 + {6'd0, rd_data[3:0]};

`ifdef INT_RX_SAT_EN
  assign w_field = (r_acc > 10'd255) ? 8'hFF : r_acc[7:0];
`else
  assign w_field = r_acc[7:0];
`endif

  always_comb begin
    w_next    = r_state;
    w_pop     = 1'b0;
    w_acc_add = 1'b0;
    w_acc_clr = 1'b0;
    w_load_a  = 1'b0;
    w_load_b  = 1'b0;
    w_load_op = 1'b0;
    w_err     = 1'b0;
    w_commit  = 1'b0;
    case (r_state)
      CAMPO_A, CAMPO_B: begin
        if (w_avail) begin
          w_pop = 1'b1;
          if (w_is_digit && (r_cnt < MAX_CNT)) begin
            w_acc_add = 1'b1;
          end else if ((rd_data == ASCII_COMA) && (r_cnt != 2'd0)) begin
            w_acc_clr = 1'b1;
            if (r_state == CAMPO_A) begin
              w_load_a = 1'b1;
              w_next   = CAMPO_B;
            end else begin
              w_load_b = 1'b1;
              w_next   = CAMPO_OP;
            end
          end else begin
            // A CR here already terminates the bad frame, so nothing to skip.
            w_err     = 1'b1;
            w_acc_clr = 1'b1;
            w_next    = (rd_data == ASCII_CR) ? CAMPO_A : DESCARTE;
          end
        end
      end
      CAMPO_OP: begin
        if (w_avail) begin
          w_pop = 1'b1;
          if (w_op_valid) begin
            w_load_op = 1'b1;
            w_next    = FIN;
          end else begin
            w_err  = 1'b1;
            w_next = DESCARTE;
          end
        end
      end
      FIN: begin
        if (w_avail) begin
          w_pop = 1'b1;
          if (rd_data == ASCII_CR) begin
            w_commit = 1'b1;
            w_next   = LISTO;
          end else begin
            w_err  = 1'b1;
            w_next = DESCARTE;
          end
        end
      end
      LISTO: w_next = CAMPO_A;
      DESCARTE: begin
        if (w_avail) begin
          w_pop     = 1'b1;
          w_acc_clr = 1'b1;
          if (rd_data == ASCII_CR) w_next = CAMPO_A;
        end
      end
      default: w_next = CAMPO_A;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state  <= CAMPO_A;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_sh_a   <= '0;
      r_sh_b   <= '0;
      r_sh_op  <= '0;
      r_dato_a <= '0;
      r_dato_b <= '0;
      r_opcode <= '0;
      r_error  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_error <= w_err;
      if (w_acc_clr) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else if (w_acc_add) begin
        r_acc <= w_acc_next;
        r_cnt <= r_cnt + 2'd1;
      end
      if (w_load_a)  r_sh_a  <= w_field;
      if (w_load_b)  r_sh_b  <= w_field;
      if (w_load_op) r_sh_op <= w_op_code;
      // Loaded on the edge into LISTO so the values and ejecutar appear together.
      if (w_commit) begin
        r_dato_a <= r_sh_a;
        r_dato_b <= r_sh_b;
        r_opcode <= r_sh_op;
      end
    end
  end

  assign RD_FIFO     = w_pop;
  assign DATO_A      = r_dato_a;
  assign DATO_B      = r_dato_b;
  assign OPCODE      = r_opcode;
  assign ejecutar    = (r_state == LISTO);
  assign error       = r_error;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_int_rx_alu_loader.sv
// Bench for int_rx_alu_loader: directed frames plus random lines checked
// against a line-level parser model.
module tb_int_rx_alu_loader;

  localparam int MAX_DIGITS = 3;
  localparam int W = 22;

  logic       CLK, RESET, fifo_empty, RD_FIFO, ejecutar, error;
  logic [7:0] rd_data, DATO_A, DATO_B;
  logic [5:0] OPCODE;
  logic [2:0] dbg_state;

  int_rx_alu_loader #(.MAX_DIGITS(MAX_DIGITS)) dut (
    .CLK(CLK), .RESET(RESET), .fifo_empty(fifo_empty), .rd_data(rd_data),
    .RD_FIFO(RD_FIFO), .DATO_A(DATO_A), .DATO_B(DATO_B), .OPCODE(OPCODE),
    .ejecutar(ejecutar), .error(error), .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
    $fatal(1);
  end

  // scoreboard state
  logic [W-1:0] exp_q[$];
  logic [7:0]   byte_q[$];
  logic [7:0]   cur_line[$];
  logic [7:0]   op_chars[8];
  logic [7:0]   last_a, last_b;
  logic [5:0]   last_op;
  int n_cmp, n_bad, exp_err, obs_err, cyc;
  int n_pops, first_pop, last_pop, exec_cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: a CR-terminated line is a frame iff it is
  // 1..MAX_DIGITS digits ',' 1..MAX_DIGITS digits ',' one operator char.
  function automatic bit model_parse(output logic [W-1:0] res);
    int i, v, n;
    logic [7:0] f0, f1, fv;
    logic [5:0] op;
    res = '0; i = 0; f0 = '0; f1 = '0; op = '0;
    for (int k = 0; k < 2; k++) begin
      v = 0; n = 0;
      while (i < cur_line.size() && cur_line[i] >= 8'h30 && cur_line[i] <= 8'h39) begin
        v = v * 10 + int'(cur_line[i] - 8'h30);
        n++; i++;
      end
      if (n < 1 || n > MAX_DIGITS) return 1'b0;
      if (i >= cur_line.size() || cur_line[i] != 8'h2C) return 1'b0;
      i++;
`ifdef INT_RX_SAT_EN
      fv = (v > 255) ? 8'd255 : 8'(v);
`else
      fv = 8'(v % 256);
`endif
      if (k == 0) f0 = fv; else f1 = fv;
    end
    if (cur_line.size() != i + 1) return 1'b0;
    case (cur_line[i])
      8'h2B: op = 6'b100000;
      8'h2D: op = 6'b100010;
      8'h26: op = 6'b100100;
      8'h7C: op = 6'b100101;
      8'h5E: op = 6'b100110;
      8'h7E: op = 6'b100111;
      8'h72: op = 6'b000011;
      8'h6C: op = 6'b000010;
      default: return 1'b0;
    endcase
    res = {f0, f1, op};
    return 1'b1;
  endfunction

  // driver tasks
  task automatic lstr(input string s);
    for (int i = 0; i < s.len(); i++) cur_line.push_back(s[i]);
  endtask

  task automatic lnum(input int nd);
    for (int i = 0; i < nd; i++) cur_line.push_back(8'h30 + 8'($urandom_range(0, 9)));
  endtask

  task automatic end_line();
    logic [W-1:0] r;
    foreach (cur_line[i]) byte_q.push_back(cur_line[i]);
    byte_q.push_back(8'h0D);
    if (model_parse(r)) exp_q.push_back(r);
    else exp_err++;
    cur_line.delete();
  endtask

  task automatic line(input string s);
    lstr(s);
    end_line();
  endtask

  task automatic random_line();
    int kind;
    kind = $urandom_range(0, 12);
    case (kind)
      7:  begin lnum(4); lstr(","); lnum(2); lstr(",+"); end
      8:  begin lstr(","); lnum(2); lstr(",-"); end
      9:  begin lnum(1); lstr(","); lnum(1); lstr(","); lnum(1); end
      10: begin lnum(1); lstr("y,3,&"); end
      11: begin lnum(2); lstr(","); lnum(2); lstr(",^|"); end
      12: ;
      default: begin
        lnum($urandom_range(1, 3)); lstr(",");
        lnum($urandom_range(1, 3)); lstr(",");
        cur_line.push_back(op_chars[$urandom_range(0, 7)]);
      end
    endcase
    end_line();
  endtask

  task automatic step(input int gate_mode);
    logic [W-1:0] e;
    logic [7:0]   b;
    bit gate;
    @(negedge CLK);
    cyc++;
    if (ejecutar) begin
      exec_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("spurious_ejecutar", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("dato_a", DATO_A, e[21:14]);
        check("dato_b", DATO_B, e[13:6]);
        check("opcode", OPCODE, e[5:0]);
        last_a = e[21:14]; last_b = e[13:6]; last_op = e[5:0];
      end
    end
    if (error) obs_err++;
    case (gate_mode)
      1:       gate = cyc[0];
      2:       gate = ($urandom_range(0, 3) == 0);
      default: gate = 1'b0;
    endcase
    fifo_empty = (byte_q.size() == 0) || gate;
    rd_data    = fifo_empty ? 8'($urandom) : byte_q[0];
    #1;
    check("pop_while_empty", RD_FIFO && fifo_empty, 0);
    if (RD_FIFO) begin
      b = byte_q.pop_front();
      n_pops++;
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
    end
  endtask

  task automatic begin_phase();
    n_pops = 0; first_pop = -1; last_pop = -1; exec_cyc = -1;
  endtask

  task automatic run_stream(input int gate_mode);
    int budget, idle;
    budget = 5000; idle = 0;
    while ((byte_q.size() != 0 || idle < 4) && budget > 0) begin
      step(gate_mode);
      budget--;
      if (byte_q.size() == 0) idle++;
    end
    if (budget == 0) check("stream_timeout", 1, 0);
    check("exp_q_drained", exp_q.size(), 0);
    check("error_count", obs_err, exp_err);
    check("hold_a", DATO_A, last_a);
    check("hold_b", DATO_B, last_b);
    check("hold_op", OPCODE, last_op);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b1; fifo_empty = 1'b0; rd_data = 8'h37;
    #1;
    check("rst_rd_fifo", RD_FIFO, 0);
    check("rst_dato_a", DATO_A, 0);
    check("rst_dato_b", DATO_B, 0);
    check("rst_opcode", OPCODE, 0);
    check("rst_ejecutar", ejecutar, 0);
    check("rst_error", error, 0);
    @(negedge CLK);
    RESET = 1'b0; fifo_empty = 1'b1;
    byte_q.delete();
    last_a = '0; last_b = '0; last_op = '0;
  endtask

  initial begin
    op_chars = '{8'h2B, 8'h2D, 8'h26, 8'h7C, 8'h5E, 8'h7E, 8'h72, 8'h6C};
    n_cmp = 0; n_bad = 0; exp_err = 0; obs_err = 0; cyc = 0;
    RESET = 1'b1; fifo_empty = 1'b1; rd_data = 8'h00;
    do_reset();

    // back-to-back frame: 7 pops then the load cycle
    begin_phase();
    line("12,7,+");
    run_stream(0);
    check("t1_pops", n_pops, 7);
    check("t1_pop_span", last_pop - first_pop, 6);
    check("t1_exec_cycle", exec_cyc, last_pop + 1);
    check("t1_a", DATO_A, 12);
    check("t1_b", DATO_B, 7);
    check("t1_op", OPCODE, 6'b100000);

    begin_phase();
    line("300,1,-");
    run_stream(0);
`ifdef INT_RX_SAT_EN
    check("big_a", DATO_A, 255);
`else
    check("big_a", DATO_A, 44);
`endif
    check("big_op", OPCODE, 6'b100010);

    begin_phase();
    line("1x,2,+");
    line("3,4,&");
    run_stream(0);
    check("recover_a", DATO_A, 3);
    check("recover_b", DATO_B, 4);
    check("recover_op", OPCODE, 6'b100100);

    begin_phase();
    line("1234,5,|");
    line(",5,|");
    line("");
    run_stream(0);

    begin_phase();
    line("9,255,^");
    run_stream(1);
    check("gap_a", DATO_A, 9);
    check("gap_b", DATO_B, 255);
    check("gap_op", OPCODE, 6'b100110);

    // abort a partial frame with reset
    begin_phase();
    byte_q.push_back(8'h35);
    byte_q.push_back(8'h2C);
    run_stream(0);
    do_reset();
    begin_phase();
    line("3,4,l");
    run_stream(0);
    check("post_rst_a", DATO_A, 3);
    check("post_rst_b", DATO_B, 4);
    check("post_rst_op", OPCODE, 6'b000010);

    for (int r = 0; r < 4; r++) begin
      begin_phase();
      for (int k = 0; k < 15; k++) random_line();
      run_stream(r % 3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/int_rx_alu_loader.md
# int_rx_alu_loader

Receive-side ALU interface for the UART calculator. It pops ASCII bytes from the UART receive FIFO and parses them into a frame of the form `<A>,<B>,<op>CR`. On a valid frame it loads operand A, operand B and the ALU opcode into registers and pulses `ejecutar` for one cycle. It sits between the RX FIFO and the ALU, mirroring the transmit-side interface that converts ALU results to ASCII for the TX FIFO.

## Interface
Parameters:
- `MAX_DIGITS`, 3: maximum decimal digits per operand field; legal range 1..3.

Ports (reset RESET, asynchronous, active-high; clock CLK):
- `CLK` input 1: clock.
- `RESET` input 1: asynchronous, active-high reset.
- `fifo_empty` input 1: RX FIFO empty flag.
- `rd_data` input 8: RX FIFO head byte (first-word fall-through, valid while `!fifo_empty`).
- `RD_FIFO` output 1: pop strobe, combinational.
- `DATO_A` output 8: operand A, registered.
- `DATO_B` output 8: operand B, registered.
- `OPCODE` output 6: ALU opcode, registered.
- `ejecutar` output 1: one-cycle pulse when a new frame is loaded.
- `error` output 1: one-cycle pulse when a malformed frame is detected.

## Operation
- States: `CAMPO_A`, `CAMPO_B`, `CAMPO_OP`, `FIN`, `LISTO`, `DESCARTE`. Reset state is `CAMPO_A`.
- Consuming states are all except `LISTO`. In a consuming state, `RD_FIFO = !fifo_empty`, and the byte is processed in that same cycle.
- `CAMPO_A` / `CAMPO_B`:
  - Digit '0'..'9' (0x30..0x39): `acc <= acc*10 + (byte-48)`. `acc` is 10 bits wide and a digit counter increments.
  - ',' (0x2C) with at least 1 digit: latch the field value into its shadow register, clear `acc` and the counter, and advance.
  - Error, go to `DESCARTE`: ',' with 0 digits, a digit beyond `MAX_DIGITS`, or any other byte.
- Field value is `acc[7:0]`, i.e. modulo 256 (see Configuration).
- `CAMPO_OP` opcode map:
  - '+' → 100000
  - '-' → 100010
  - '&' → 100100
  - '|' → 100101
  - '^' → 100110
  - '~' → 100111
  - 'r' → 000011
  - 'l' → 000010
  - Any other byte → `DESCARTE`.
- `FIN`: CR (0x0D) → `LISTO`; any other byte → `DESCARTE`.
- `LISTO`: copy the shadow A/B/op registers into `DATO_A`/`DATO_B`/`OPCODE`, assert `ejecutar`, then go to `CAMPO_A`. No pop in this state.
- `DESCARTE`: `error` is high on the entry cycle only. Pop bytes until CR, then go to `CAMPO_A` with `acc` and counter cleared. Output registers are not modified.
- CR seen in `CAMPO_A` or `CAMPO_B` is an error. That CR ends the discard immediately: the next state is `CAMPO_A`, `error` pulses, and no further bytes are skipped.
- `DATO_*` and `OPCODE` hold their values until the next valid frame.

## Timing
- Reset values: `DATO_A=0`, `DATO_B=0`, `OPCODE=0`, `ejecutar=0`, `error=0`, `RD_FIFO=0`. `acc`, counter and shadow registers are cleared.
- Throughput: at most one byte popped per cycle.
- `fifo_empty` high: no pop and no state change.
- Latency: the `LISTO` cycle follows the cycle in which CR is popped. Outputs update and `ejecutar` rises on the same edge.
- A 7-byte frame with the FIFO never empty takes 7 pop cycles plus 1 `LISTO` cycle. Popping resumes on the cycle after `LISTO`.
- RESET asserted mid-frame aborts the partial frame immediately. Bytes already popped are lost and parsing restarts in `CAMPO_A`.

## Configuration
- `INT_RX_SAT_EN` defined: field value = `(acc > 255) ? 255 : acc[7:0]`.
- `INT_RX_SAT_EN` undefined: field value = `acc[7:0]` (wrap-around, e.g. 300 → 44).
- Parsing, states and timing are identical in both builds.

## Structure
- Shared package holds:
  - ASCII constants: `ASCII_0`=48, `ASCII_COMA`=0x2C, `ASCII_CR`=0x0D.
  - The 6-bit ALU opcode constants, shared with the ALU and the TX interface.
  - State encoding (3 bits).
- Natural sub-module: `ascii_op_decode`, a combinational char → {valid, opcode[5:0]} lookup reused by test benches.

## Test plan
- Frame "12,7,+" CR with FIFO continuously full:
  - 7 consecutive `RD_FIFO` cycles.
  - Next cycle: `ejecutar`=1, `DATO_A`=12, `DATO_B`=7, `OPCODE`=100000.
- "300,1,-" CR:
  - Without `INT_RX_SAT_EN`: `DATO_A`=44, `OPCODE`=100010.
  - With `INT_RX_SAT_EN`: `DATO_A`=255.
- "1x,2,+" CR followed by "3,4,&" CR:
  - `error` pulses once, no `ejecutar` for the first frame, outputs keep their previous values.
  - Second frame yields A=3, B=4, `OPCODE`=100100.
- "1234,5,|" CR (`MAX_DIGITS`=3): `error` pulse on the 4th digit, no `ejecutar`. Likewise ",5,|" CR → `error`.
- Frame "9,255,^" CR with `fifo_empty` toggling every other cycle:
  - `RD_FIFO` asserts only when `!fifo_empty`.
  - Result A=9, B=255, `OPCODE`=100110.
- RESET pulsed after "5," then frame "3,4,l" CR:
  - Outputs are 0 immediately after reset.
  - Final A=3, B=4, `OPCODE`=000010.
